// File: rtl/cacheline_pkg.sv
// rtl/cacheline_pkg.sv - shared constants, types and address helper for the cacheline adaptor
package cacheline_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int BURST_WIDTH = 64;
    localparam int ADDR_WIDTH  = 32;
    localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int BEAT_BITS   = $clog2(BEATS);
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } adaptor_state_t;

    // Line viewed as BEATS beats so a beat index selects a slice directly.
    typedef logic [BEATS-1:0][BURST_WIDTH-1:0] line_t;
    typedef logic [BURST_WIDTH-1:0]            beat_t;
    typedef logic [BEAT_BITS-1:0]              beat_idx_t;

    localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

    // Clears the byte-within-line offset so bursts always start on a line boundary.
    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ~OFFSET_MASK;
    endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - converts 256-bit cache line requests into 4-beat 64-bit bursts
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   pmem_read/write   line request from the cache, held until pmem_resp
//   pmem_address      line address (low offset bits ignored)
//   pmem_wdata        line to write
//   pmem_resp         one-cycle completion pulse
//   pmem_rdata        last completed read line
//   address_o         line-aligned burst base address
//   burst_o/burst_i   outgoing write beat / incoming read beat
//   read_o/write_o    burst requests toward memory
//   resp_i            memory beat strobe, one beat per high cycle
module cacheline_adaptor
    import cacheline_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pmem_read,
    input  logic                   pmem_write,
    input  logic [ADDR_WIDTH-1:0]  pmem_address,
    input  logic [LINE_WIDTH-1:0]  pmem_wdata,
    output logic                   pmem_resp,
    output logic [LINE_WIDTH-1:0]  pmem_rdata,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    adaptor_state_t        state;
    adaptor_state_t        state_next;
    beat_idx_t             beat;
    line_t                 line_buf;
    line_t                 rdata_q;
    line_t                 line_merged;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  last_beat;

    assign last_beat = resp_i && (beat == LAST_BEAT);

    // Read line as it will look once the beat on burst_i lands; lets the
    // visible read register load on the final beat edge without an extra cycle.
    always_comb begin
        line_merged       = line_buf;
        line_merged[beat] = beat_t'(burst_i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                // Write wins if the cache raises both; the line still completes.
                if (pmem_write) begin
                    state_next = WR;
                end else if (pmem_read) begin
                    state_next = RD;
                end
            end
            RD: begin
                if (last_beat) begin
                    state_next = DONE;
                end
            end
            WR: begin
                if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: beat counter, line buffer, address and read-result registers.
    // rdata_q is written only by reads, so write traffic never disturbs pmem_rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat     <= '0;
            line_buf <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    beat <= '0;
                    if (pmem_write) begin
                        line_buf <= pmem_wdata;
                        addr_q   <= line_align(pmem_address);
                    end else if (pmem_read) begin
                        addr_q   <= line_align(pmem_address);
                    end
                end
                RD: begin
                    if (resp_i) begin
                        line_buf[beat] <= beat_t'(burst_i);
                        beat           <= beat + beat_idx_t'(1);
                        if (beat == LAST_BEAT) begin
                            rdata_q <= line_merged;
                        end
                    end
                end
                WR: begin
                    if (resp_i) begin
                        beat <= beat + beat_idx_t'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        pmem_resp  = (state == DONE);
        pmem_rdata = rdata_q;
        address_o  = addr_q;
        // The counter only leaves zero once the first beat is taken, so this
        // holds read_o high exactly until the first accepted beat.
        read_o     = (state == RD) && (beat == '0);
        write_o    = (state == WR);
        burst_o    = (state == WR) ? line_buf[beat] : '0;
    end

endmodule
